// File: rtl/led_blink_driver_if.sv
// Request/status bundle between the event source and the LED blink driver.
// The master side issues requests; the slave side is the driver.
interface led_blink_driver_if;
    logic       trig;
    logic [3:0] cnt;
    logic       abort;
    logic       led;
    logic       busy;
    logic       done;
    logic       ovf;

    modport master (output trig, cnt, abort, input  led, busy, done, ovf);
    modport slave  (input  trig, cnt, abort, output led, busy, done, ovf);
endinterface

// File: rtl/led_blink_driver.sv
// Turns single-cycle blink requests into timed ON/OFF LED sequences,
// with a one-deep pending slot and a sticky overflow flag for dropped requests.
module led_blink_driver #(
    parameter int TICK_W    = 25,
    parameter int ON_TICKS  = 12500000,
    parameter int OFF_TICKS = 12500000
) (
    input  logic                clk,
    input  logic                rst,
    led_blink_driver_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [3:0]        rem_q, rem_d;
    logic [3:0]        pend_cnt_q, pend_cnt_d;
    logic              pend_valid_q, pend_valid_d;
    logic              led_q, busy_q, done_q, ovf_q;
    logic              done_d, ovf_d;
    logic              req, complete;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            rem_q        <= '0;
            pend_cnt_q   <= '0;
            pend_valid_q <= 1'b0;
            led_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            rem_q        <= rem_d;
            pend_cnt_q   <= pend_cnt_d;
            pend_valid_q <= pend_valid_d;
            led_q        <= (state_d == ON);
            busy_q       <= (state_d != IDLE) | pend_valid_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        rem_d        = rem_q;
        pend_cnt_d   = pend_cnt_q;
        pend_valid_d = pend_valid_q;
        done_d       = 1'b0;
        ovf_d        = ovf_q;
        req          = bus.trig && (bus.cnt != 4'd0);
        complete     = (state_q == OFF) && (tick_q == OFF_LAST) && (rem_q == 4'd0);

        if (bus.abort) begin
            state_d      = IDLE;
            tick_d       = '0;
            rem_d        = '0;
            pend_cnt_d   = '0;
            pend_valid_d = 1'b0;
        end else if (complete) begin
            // Chain straight into the next source so there is no idle gap.
            done_d = 1'b1;
            tick_d = '0;
            if (pend_valid_q) begin
                state_d      = ON;
                rem_d        = pend_cnt_q;
                pend_valid_d = req;
                pend_cnt_d   = req ? bus.cnt : pend_cnt_q;
            end else if (req) begin
                state_d = ON;
                rem_d   = bus.cnt;
            end else begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        state_d = ON;
                        tick_d  = '0;
                        rem_d   = bus.cnt;
                    end
                end
                ON: begin
                    if (tick_q == ON_LAST) begin
                        state_d = OFF;
                        tick_d  = '0;
                        rem_d   = rem_q - 4'd1;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                OFF: begin
                    if (tick_q == OFF_LAST) begin
                        state_d = ON;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (req && state_q != IDLE) begin
                if (!pend_valid_q) begin
                    pend_valid_d = 1'b1;
                    pend_cnt_d   = bus.cnt;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_led_blink_driver.sv
// Directed bench for led_blink_driver with ON_TICKS=3, OFF_TICKS=2.
// Expected per-cycle patterns are bit vectors, bit i = i-th sampled cycle.
module tb_led_blink_driver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    led_blink_driver_if bif ();

    led_blink_driver #(.TICK_W(4), .ON_TICKS(3), .OFF_TICKS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic l, input logic b, input logic d, input logic o);
        chk({tag, ".led"},  32'(bif.led),  32'(l));
        chk({tag, ".busy"}, 32'(bif.busy), 32'(b));
        chk({tag, ".done"}, 32'(bif.done), 32'(d));
        chk({tag, ".ovf"},  32'(bif.ovf),  32'(o));
    endtask

    // Checks the current cycle, then n-1 further cycles.
    task automatic run_chk(input string tag, input int n, input logic [31:0] led_e,
                           input logic [31:0] busy_e, input logic [31:0] done_e,
                           input logic [31:0] ovf_e);
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            chk_all($sformatf("%s[%0d]", tag, i), led_e[i], busy_e[i], done_e[i], ovf_e[i]);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) step();
        rst = 1'b1;
        bif.trig = 1'b0;
        bif.cnt  = 4'd0;
        step();
    endtask

    task automatic send(input logic [3:0] c);
        bif.trig = 1'b1;
        bif.cnt  = c;
        step();
        bif.trig = 1'b0;
        bif.cnt  = 4'd0;
    endtask

    // cnt=4 sequence, pending cnt=2, an overflowing cnt=1; ends in first cycle of ON #2.
    task automatic setup_abort_case();
        do_reset(2);
        send(4'd4);           // cycle t+1
        step();               // t+2
        send(4'd2);           // t+3: stored in slot
        chk_all("ab.pend", 1'b1, 1'b1, 1'b0, 1'b0);
        send(4'd1);           // t+4: dropped
        chk_all("ab.ovf", 1'b0, 1'b1, 1'b0, 1'b1);
        step();               // t+5
        step();               // t+6: second ON phase
        chk_all("ab.on2", 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        bif.trig  = 1'b0;
        bif.cnt   = 4'd0;
        bif.abort = 1'b0;

        // 1: reset dominates a live request
        rst = 1'b0;
        bif.trig = 1'b1;
        bif.cnt  = 4'd5;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all($sformatf("rst[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        bif.trig = 1'b0;
        bif.cnt  = 4'd0;
        step();

        // 2: two blinks: ON 3, OFF 2, ON 3, OFF 2, then done
        send(4'd2);
        run_chk("basic", 11, 32'b00011100111, 32'b01111111111, 32'b10000000000, 32'd0);
        step();

        // 3: cnt=0 is ignored
        send(4'd0);
        run_chk("zero", 20, 32'd0, 32'd0, 32'd0, 32'd0);

        // 4: pending slot and overflow
        step();
        send(4'd1);           // cycle 11
        chk_all("pend.c11", 1'b1, 1'b1, 1'b0, 1'b0);
        step();               // cycle 12
        send(4'd3);           // cycle 13
        chk_all("pend.c13", 1'b1, 1'b1, 1'b0, 1'b0);
        send(4'd2);           // cycle 14
        run_chk("pend", 18, 32'b000111001110011100, 32'b011111111111111111,
                32'b100000000000000100, 32'h3FFFF);

        // 5: trig on the last OFF edge bypasses the slot
        do_reset(2);
        send(4'd1);           // t+1
        for (int i = 0; i < 4; i++) step();   // t+5, last OFF cycle
        send(4'd1);           // t+6
        run_chk("bypass", 6, 32'b000111, 32'b011111, 32'b100001, 32'd0);

        // 6a: abort clears everything but ovf; concurrent trig is dropped
        setup_abort_case();
        bif.abort = 1'b1;
        send(4'd3);
        bif.abort = 1'b0;
        run_chk("abort", 10, 32'd0, 32'd0, 32'd0, 32'h3FF);

        // 6b: same case with a mid-sequence reset
        setup_abort_case();
        rst = 1'b0;
        step();
        rst = 1'b1;
        run_chk("midrst", 10, 32'd0, 32'd0, 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
